// File: rtl/writeback_trace_pkg.sv
// Shared types for the writeback tracer: the buffered packet, the header
// bit layout and the serializer state encoding.
// Optional feature macro: TRACE_MEM_ADDRESS_EN (adds the memory-address word).
package writeback_trace_pkg;

   // Header word layout
   localparam int HDR_OVF_BIT   = 31;
   localparam int HDR_STORE_BIT = 30;
   localparam int HDR_LOAD_BIT  = 29;
   localparam int HDR_DEST_LSB  = 24;
   localparam int HDR_SEQ_LSB   = 16;
   localparam int HDR_DELTA_LSB = 0;
   localparam int HDR_DELTA_W   = 16;

   // Serializer states; MEMADDR only exists when memory addresses are traced
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEADER  = 3'd1,
      ST_IADDR   = 3'd2,
`ifdef TRACE_MEM_ADDRESS_EN
      ST_RESULT  = 3'd3,
      ST_MEMADDR = 3'd4
`else
      ST_RESULT  = 3'd3
`endif
   } ser_state_e;

   // One captured event, everything needed to emit its words later
   typedef struct packed {
      logic        overflow;
      logic        store;
      logic        load;
      logic [4:0]  dest;
      logic [7:0]  seq;
      logic [15:0] delta;
      logic [31:0] iaddr;
      logic [31:0] result;
`ifdef TRACE_MEM_ADDRESS_EN
      logic [31:0] mem_addr;
`endif
   } trace_pkt_t;

   // Build the header word of a packet
   function automatic logic [31:0] pack_header(input trace_pkt_t p);
      logic [31:0] h;
      h = '0;
      h[HDR_OVF_BIT]                 = p.overflow;
      h[HDR_STORE_BIT]               = p.store;
      h[HDR_LOAD_BIT]                = p.load;
      h[HDR_DEST_LSB +: 5]           = p.dest;
      h[HDR_SEQ_LSB +: 8]            = p.seq;
      h[HDR_DELTA_LSB +: HDR_DELTA_W] = p.delta;
      return h;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace packets. Pushes while full and pops while empty
// are ignored. Read data is the current head, valid whenever not empty.
module trace_fifo
   import writeback_trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       push_i,
   input  trace_pkt_t wdata_i,
   input  logic       pop_i,
   output trace_pkt_t rdata_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);

   trace_pkt_t     mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic           do_push, do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer next-state: advance on accepted push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers; reset empties the FIFO
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, written at the tail on an accepted push
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/writeback_tracer.sv
// CPU writeback tracer: captures retired results into a packet FIFO and
// serializes each packet as header / iaddress / result [/ mem_address] words
// over a valid/ready stream.
// Optional feature macro: TRACE_MEM_ADDRESS_EN.
// Handshake: a word transfers on a rising edge where trace_valid_o and
// trace_ready_i are both high; while ready is low the word and last flag hold.
module writeback_tracer
   import writeback_trace_pkg::*;
#(
   parameter int TRACE_DEPTH = 16,
   parameter int DELTA_WIDTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        trace_enable_i,
   input  logic        writeback_i,
   input  logic [31:0] iaddress_i,
   input  logic [31:0] result_i,
   input  logic [4:0]  destination_i,
   input  logic        store_i,
   input  logic        load_i,
   input  logic [31:0] mem_address_i,
   output logic        trace_valid_o,
   input  logic        trace_ready_i,
   output logic [31:0] trace_data_o,
   output logic        trace_last_o,
   output logic        overflow_o,
   output logic [15:0] dropped_count_o,
   output logic [2:0]  dbg_state_o
);

   ser_state_e             state_q, state_d;
   logic [DELTA_WIDTH-1:0] delta_q, delta_d;
   logic [7:0]             seq_q, seq_d;
   logic                   pend_ovf_q, pend_ovf_d;
   logic                   overflow_q, overflow_d;
   logic [15:0]            dropped_q, dropped_d;
   logic [15:0]            delta_hdr;
   logic                   fifo_full, fifo_empty, fifo_pop;
   logic                   capture, drop;
   trace_pkt_t             wpkt, pkt;

`ifndef TRACE_MEM_ADDRESS_EN
   logic unused_mem_address;
   assign unused_mem_address = ^mem_address_i;
`endif

   // Full is the pre-pop flag, so an event arriving while full is dropped
   assign capture = writeback_i & trace_enable_i & ~fifo_full;
   assign drop    = writeback_i & trace_enable_i & fifo_full;

   // Clamp the delta counter into the 16-bit header field
   always_comb begin
      delta_hdr = 16'(delta_q);
      if (DELTA_WIDTH > HDR_DELTA_W && |(delta_q >> HDR_DELTA_W)) delta_hdr = '1;
   end

   // Assemble the packet for the event on the inputs this cycle
   always_comb begin
      wpkt          = '0;
      wpkt.overflow = pend_ovf_q;
      wpkt.store    = store_i;
      wpkt.load     = load_i & ~store_i;
      wpkt.dest     = destination_i;
      wpkt.seq      = seq_q;
      wpkt.delta    = delta_hdr;
      wpkt.iaddr    = iaddress_i;
      wpkt.result   = result_i;
`ifdef TRACE_MEM_ADDRESS_EN
      wpkt.mem_addr = mem_address_i;
`endif
   end

   trace_fifo #(.DEPTH(TRACE_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (capture),
      .wdata_i (wpkt),
      .pop_i   (fifo_pop),
      .rdata_o (pkt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Counter next-state: delta restarts at 1 on capture so the next event
   // sees the number of edges since this one; drops mark the next packet
   always_comb begin
      delta_d    = delta_q;
      seq_d      = seq_q;
      pend_ovf_d = pend_ovf_q;
      overflow_d = overflow_q;
      dropped_d  = dropped_q;
      if (capture) begin
         delta_d    = '0;
         delta_d[0] = 1'b1;
         seq_d      = seq_q + 8'd1;
         pend_ovf_d = 1'b0;
      end else if (delta_q != {DELTA_WIDTH{1'b1}}) begin
         delta_d = delta_q + 1'b1;
      end
      if (drop) begin
         pend_ovf_d = 1'b1;
         overflow_d = 1'b1;
         if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
      end
   end

   // Counter and flag registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         delta_q    <= '0;
         seq_q      <= '0;
         pend_ovf_q <= 1'b0;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
      end else begin
         delta_q    <= delta_d;
         seq_q      <= seq_d;
         pend_ovf_q <= pend_ovf_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   assign overflow_o      = overflow_q;
   assign dropped_count_o = dropped_q;
   assign dbg_state_o     = state_q;

   // Serializer next-state and stream outputs; the FIFO head is popped when
   // the last word of its packet is accepted
   always_comb begin
      state_d       = state_q;
      trace_valid_o = 1'b0;
      trace_data_o  = '0;
      trace_last_o  = 1'b0;
      fifo_pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_HEADER;
         end
         ST_HEADER: begin
            trace_valid_o = 1'b1;
            trace_data_o  = pack_header(pkt);
            if (trace_ready_i) state_d = ST_IADDR;
         end
         ST_IADDR: begin
            trace_valid_o = 1'b1;
            trace_data_o  = pkt.iaddr;
            if (trace_ready_i) state_d = ST_RESULT;
         end
         ST_RESULT: begin
            trace_valid_o = 1'b1;
            trace_data_o  = pkt.result;
`ifdef TRACE_MEM_ADDRESS_EN
            trace_last_o  = ~(pkt.store | pkt.load);
            if (trace_ready_i) begin
               if (pkt.store | pkt.load) begin
                  state_d = ST_MEMADDR;
               end else begin
                  fifo_pop = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
`else
            trace_last_o  = 1'b1;
            if (trace_ready_i) begin
               fifo_pop = 1'b1;
               state_d  = ST_IDLE;
            end
`endif
         end
`ifdef TRACE_MEM_ADDRESS_EN
         ST_MEMADDR: begin
            trace_valid_o = 1'b1;
            trace_data_o  = pkt.mem_addr;
            trace_last_o  = 1'b1;
            if (trace_ready_i) begin
               fifo_pop = 1'b1;
               state_d  = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Serializer state register; reset abandons any packet in flight
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

endmodule

// File: tb/tb_writeback_tracer.sv
// Testbench for writeback_tracer: directed events with a packet-level model
// of the expected word stream plus literal spot checks.
`timescale 1ns/1ps
module tb_writeback_tracer;

   localparam int DEPTH = 16;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        trace_enable = 1'b1;
   logic        writeback = 1'b0;
   logic [31:0] iaddr = '0;
   logic [31:0] result = '0;
   logic [4:0]  dest = '0;
   logic        store = 1'b0;
   logic        load = 1'b0;
   logic [31:0] mem_addr = '0;
   logic        trace_ready = 1'b1;
   logic        trace_valid;
   logic [31:0] trace_data;
   logic        trace_last;
   logic        overflow;
   logic [15:0] dropped;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   writeback_tracer #(.TRACE_DEPTH(DEPTH), .DELTA_WIDTH(16)) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .trace_enable_i  (trace_enable),
      .writeback_i     (writeback),
      .iaddress_i      (iaddr),
      .result_i        (result),
      .destination_i   (dest),
      .store_i         (store),
      .load_i          (load),
      .mem_address_i   (mem_addr),
      .trace_valid_o   (trace_valid),
      .trace_ready_i   (trace_ready),
      .trace_data_o    (trace_data),
      .trace_last_o    (trace_last),
      .overflow_o      (overflow),
      .dropped_count_o (dropped),
      .dbg_state_o     (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q[$];     // {last, word} still to be emitted
   logic [32:0] acc_log[$];   // {last, word} accepted by the consumer
   logic        acc_flag = 1'b0;
   int          occ = 0;
   int unsigned cyc = 0;
   int unsigned last_cap = 1;
   logic [7:0]  m_seq = '0;
   logic        m_pend_ovf = 1'b0;
   logic        m_ovf = 1'b0;
   int          m_drop = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=0x%08h expected=0x%08h", name, got, want);
      end
   endtask

   // ---------------- behavioural model ----------------
   task automatic model_reset();
      exp_q.delete();
      occ        = 0;
      cyc        = 0;
      last_cap   = 1;
      m_seq      = '0;
      m_pend_ovf = 1'b0;
      m_ovf      = 1'b0;
      m_drop     = 0;
   endtask

   task automatic model_step();
      logic        full;
      logic        st, ld;
      logic [32:0] w;
      int unsigned d;
      cyc++;
      full = (occ == DEPTH);
      if (acc_flag && exp_q.size() > 0) begin
         w = exp_q.pop_front();
         if (w[32]) occ--;
      end
      if (writeback && trace_enable) begin
         if (full) begin
            m_ovf      = 1'b1;
            m_pend_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
         end else begin
            st = store;
            ld = load & ~store;
            d  = cyc - last_cap;
            if (d > 65535) d = 65535;
            exp_q.push_back({1'b0, m_pend_ovf, st, ld, dest, m_seq, d[15:0]});
            exp_q.push_back({1'b0, iaddr});
`ifdef TRACE_MEM_ADDRESS_EN
            if (st | ld) begin
               exp_q.push_back({1'b0, result});
               exp_q.push_back({1'b1, mem_addr});
            end else begin
               exp_q.push_back({1'b1, result});
            end
`else
            exp_q.push_back({1'b1, result});
`endif
            m_seq++;
            m_pend_ovf = 1'b0;
            last_cap   = cyc;
            occ++;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // ---------------- compare process (falling edge) ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acc_flag = 1'b0;
         end else begin
            acc_flag = 1'b0;
            if (trace_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_word got=0x%08h expected=no_word", trace_data);
               end else begin
                  check("stream_data", trace_data, exp_q[0][31:0]);
                  check("stream_last", {31'b0, trace_last}, {31'b0, exp_q[0][32]});
                  acc_flag = trace_ready;
                  if (trace_ready) acc_log.push_back({trace_last, trace_data});
               end
            end
            check("overflow_o", {31'b0, overflow}, {31'b0, m_ovf});
            check("dropped_count_o", {16'b0, dropped}, {16'b0, m_drop[15:0]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic put_event(input logic [4:0] d, input logic [31:0] ia, input logic [31:0] res,
                            input logic st, input logic ld, input logic [31:0] ma);
      writeback = 1'b1;
      dest      = d;
      iaddr     = ia;
      result    = res;
      store     = st;
      load      = ld;
      mem_addr  = ma;
      cycle();
   endtask

   task automatic clear_event();
      writeback = 1'b0;
      store     = 1'b0;
      load      = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int max_cycles);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || trace_valid) && n < max_cycles) begin
         cycle();
         n++;
      end
      checks++;
      if (n >= max_cycles) begin
         errors++;
         $display("FAIL %s drain_timeout got=%0d_words_pending expected=0", name, exp_q.size());
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int base;
      int n;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", {31'b0, trace_valid}, 32'd0);
      check("reset_data", trace_data, 32'd0);
      check("reset_last", {31'b0, trace_last}, 32'd0);
      check("reset_overflow", {31'b0, overflow}, 32'd0);
      check("reset_dropped", {16'b0, dropped}, 32'd0);
      rst_n = 1'b1;
      cycle();

      // Single ALU event, latency and word order
      base = acc_log.size();
      put_event(5'd5, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
      clear_event();
      check("latency_edge_n", {31'b0, trace_valid}, 32'd0);
      cycle();
      check("latency_edge_n1", {31'b0, trace_valid}, 32'd1);
      wait_drain("alu", 20);
      check("alu_words", acc_log.size() - base, 32'd3);
      check("alu_header", {16'b0, acc_log[base][31:16]}, 32'h0500);
      check("alu_delta", {16'b0, acc_log[base][15:0]}, 32'd1);
      check("alu_iaddr", acc_log[base+1][31:0], 32'h100);
      check("alu_result", acc_log[base+2][31:0], 32'hDEADBEEF);
      check("alu_last_hdr", {31'b0, acc_log[base][32]}, 32'd0);
      check("alu_last_final", {31'b0, acc_log[base+2][32]}, 32'd1);

      // Store with memory address
      base = acc_log.size();
      put_event(5'd7, 32'h200, 32'h12345678, 1'b1, 1'b0, 32'h2000);
      clear_event();
      wait_drain("store", 20);
      check("store_header", {16'b0, acc_log[base][31:16]}, 32'h4701);
`ifdef TRACE_MEM_ADDRESS_EN
      check("store_words", acc_log.size() - base, 32'd4);
      check("store_memaddr", acc_log[base+3][31:0], 32'h00002000);
      check("store_memaddr_last", {31'b0, acc_log[base+3][32]}, 32'd1);
`else
      check("store_words", acc_log.size() - base, 32'd3);
      check("store_result_last", {31'b0, acc_log[base+2][32]}, 32'd1);
`endif

      // Store and load together encode as store only
      base = acc_log.size();
      put_event(5'd3, 32'h204, 32'h0, 1'b1, 1'b1, 32'h3000);
      clear_event();
      wait_drain("store_load", 20);
      check("store_load_header", {16'b0, acc_log[base][31:16]}, 32'h4302);

      // Capture disabled: nothing emitted, nothing dropped
      base = acc_log.size();
      trace_enable = 1'b0;
      put_event(5'd1, 32'h400, 32'h1, 1'b0, 1'b0, 32'h0);
      clear_event();
      trace_enable = 1'b1;
      repeat (4) cycle();
      check("disabled_words", acc_log.size() - base, 32'd0);

      // Two events three edges apart
      base = acc_log.size();
      put_event(5'd1, 32'h500, 32'hA, 1'b0, 1'b0, 32'h0);
      clear_event();
      cycle();
      cycle();
      put_event(5'd2, 32'h504, 32'hB, 1'b0, 1'b0, 32'h0);
      clear_event();
      wait_drain("delta3", 30);
      check("delta3_delta", {16'b0, acc_log[base+3][15:0]}, 32'd3);
      check("delta3_seq", {24'b0, acc_log[base+3][23:16]}, 32'd4);

      // Overflow: 18 events with the consumer stalled
      base = acc_log.size();
      trace_ready = 1'b0;
      for (int i = 0; i < 18; i++) put_event(5'd2, 32'h1000 + i, i, 1'b0, 1'b0, 32'h0);
      clear_event();
      check("ovf_flag", {31'b0, overflow}, 32'd1);
      check("ovf_dropped", {16'b0, dropped}, 32'd2);
      trace_ready = 1'b1;
      wait_drain("ovf_drain", 200);
      check("ovf_words", acc_log.size() - base, 32'd48);
      base = acc_log.size();
      put_event(5'd6, 32'h600, 32'hC, 1'b0, 1'b0, 32'h0);
      clear_event();
      put_event(5'd6, 32'h604, 32'hD, 1'b0, 1'b0, 32'h0);
      clear_event();
      wait_drain("ovf_next", 30);
      check("ovf_next_bit", {31'b0, acc_log[base][31]}, 32'd1);
      check("ovf_next_seq", {24'b0, acc_log[base][23:16]}, 32'h15);
      check("ovf_after_bit", {31'b0, acc_log[base+3][31]}, 32'd0);

      // Reset while the RESULT word is stalled
      trace_ready = 1'b0;
      put_event(5'd9, 32'h300, 32'h55AA55AA, 1'b0, 1'b0, 32'h0);
      clear_event();
      n = 0;
      while (!trace_valid && n < 10) begin
         cycle();
         n++;
      end
      check("rst_mid_header_seen", {31'b0, trace_valid}, 32'd1);
      trace_ready = 1'b1;
      cycle();
      cycle();
      trace_ready = 1'b0;
      cycle();
      check("rst_mid_result_held", trace_data, 32'h55AA55AA);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", {31'b0, trace_valid}, 32'd0);
      check("rst_mid_data", trace_data, 32'd0);
      check("rst_mid_last", {31'b0, trace_last}, 32'd0);
      check("rst_mid_overflow", {31'b0, overflow}, 32'd0);
      check("rst_mid_dropped", {16'b0, dropped}, 32'd0);
      cycle();
      cycle();
      rst_n = 1'b1;
      trace_ready = 1'b1;
      cycle();
      base = acc_log.size();
      put_event(5'd4, 32'h700, 32'hE, 1'b0, 1'b0, 32'h0);
      clear_event();
      wait_drain("post_reset", 20);
      check("post_reset_header", {16'b0, acc_log[base][31:16]}, 32'h0400);

      // Saturating delta: events 70000 edges apart
      base = acc_log.size();
      put_event(5'd8, 32'h800, 32'hF, 1'b0, 1'b0, 32'h0);
      clear_event();
      repeat (69999) cycle();
      put_event(5'd8, 32'h804, 32'h10, 1'b0, 1'b0, 32'h0);
      clear_event();
      wait_drain("delta_sat", 30);
      check("delta_sat_delta", {16'b0, acc_log[base+3][15:0]}, 32'h0000FFFF);

      repeat (2) cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
